// File: rtl/shift_seq_ctrl.sv
// Sequencer that drives sl/sr/din of an external shift register for N shifts, then pulses done.
// Optional rotate mode (din taken from q) is compiled in with macro SHIFT_SEQ_ROTATE_EN.
module shift_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             dir,
    input  logic [3:0]       count,
    input  logic [WIDTH-1:0] pattern,
    input  logic [WIDTH-1:0] q,
`ifdef SHIFT_SEQ_ROTATE_EN
    input  logic             rotate,
`endif
    output logic             sl,
    output logic             sr,
    output logic             din,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] WMAX = 4'(WIDTH);

    state_t           state_r;
    logic             dir_r;
    logic [3:0]       rem_r;
    logic [3:0]       idx_r;
    logic [WIDTH-1:0] pattern_r;
    logic [3:0]       n_s;
    logic             pat_bit_s;
`ifdef SHIFT_SEQ_ROTATE_EN
    logic             rotate_r;
    logic             rot_bit_s;
`else
    logic             unused_q_s;
`endif

    assign n_s = (count > WMAX) ? WMAX : count;

    // Command FSM: latch on accepted start, count shifts down to the last one, then pulse done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            dir_r     <= 1'b0;
            rem_r     <= 4'd0;
            idx_r     <= 4'd0;
            pattern_r <= '0;
`ifdef SHIFT_SEQ_ROTATE_EN
            rotate_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        if (count != 4'd0) begin
                            dir_r     <= dir;
                            pattern_r <= pattern;
                            rem_r     <= n_s;
                            // left shifts feed the pattern MSB-first from bit N-1 down
                            idx_r     <= dir ? 4'd0 : (n_s - 4'd1);
`ifdef SHIFT_SEQ_ROTATE_EN
                            rotate_r  <= rotate;
`endif
                            state_r   <= SHIFT;
                        end else begin
                            state_r   <= DONE;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    if (rem_r == 4'd1) begin
                        rem_r   <= 4'd0;
                        state_r <= DONE;
                    end else begin
                        rem_r <= rem_r - 4'd1;
                        idx_r <= dir_r ? (idx_r + 4'd1) : (idx_r - 4'd1);
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state_r == SHIFT);
    assign sl   = busy & ~dir_r;
    assign sr   = busy & dir_r;
    assign done = (state_r == DONE);

    assign pat_bit_s = |(pattern_r & (WIDTH'(1) << idx_r));

`ifdef SHIFT_SEQ_ROTATE_EN
    assign rot_bit_s = dir_r ? q[0] : q[WIDTH-1];
    assign din       = busy & (rotate_r ? rot_bit_s : pat_bit_s);
`else
    assign unused_q_s = ^q;
    assign din        = busy & pat_bit_s;
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: timeline reference model, directed cases, random traffic.
module tb_shift_seq_ctrl;
    localparam int W = 8;
    localparam int SLOTS = 4096;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         dir = 1'b0;
    logic [3:0]   count = 4'd0;
    logic [W-1:0] pattern = '0;
    logic [W-1:0] reg_q = '0;
    logic         rotate = 1'b0;
    logic         preset_en = 1'b0;
    logic [W-1:0] preset_val = '0;
    logic         sl, sr, din, busy, done;

    shift_seq_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .dir(dir), .count(count),
        .pattern(pattern), .q(reg_q),
`ifdef SHIFT_SEQ_ROTATE_EN
        .rotate(rotate),
`endif
        .sl(sl), .sr(sr), .din(din), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // the controlled shift register, moved only by the DUT's commands
    always @(posedge clk) begin
        if (preset_en) reg_q <= preset_val;
        else if (sl)   reg_q <= {reg_q[W-2:0], din};
        else if (sr)   reg_q <= {din, reg_q[W-1:1]};
    end

    // expected outputs per cycle slot (slot = number of edges seen so far)
    bit exp_sl[SLOTS], exp_sr[SLOTS], exp_din[SLOTS], exp_busy[SLOTS];
    bit exp_done[SLOTS], exp_rot[SLOTS], exp_dir[SLOTS];
    int cyc = 0;
    int free_at = 0;
    int last_acc = 0;
    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;
    int shifts_seen = 0, dones_seen = 0, busy_seen = 0, last_done = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    // reference model: on every edge, schedule the whole output timeline of an accepted command
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                for (int s = cyc; s < cyc + 20 && s < SLOTS; s++) begin
                    exp_sl[s] = 0; exp_sr[s] = 0; exp_din[s] = 0; exp_busy[s] = 0;
                    exp_done[s] = 0; exp_rot[s] = 0;
                end
                free_at = cyc + 1;
            end else if (start && cyc >= free_at) begin
                int n;
                n = (int'(count) > W) ? W : int'(count);
                for (int i = 0; i < n; i++) begin
                    exp_busy[cyc+i] = 1;
                    exp_sl[cyc+i]   = !dir;
                    exp_sr[cyc+i]   = dir;
                    exp_dir[cyc+i]  = dir;
                    exp_din[cyc+i]  = dir ? pattern[i] : pattern[n-1-i];
`ifdef SHIFT_SEQ_ROTATE_EN
                    exp_rot[cyc+i]  = rotate;
`endif
                end
                exp_done[cyc+n] = 1;
                last_acc = cyc;
                free_at = cyc + n + 2;
            end
        end
    end

    // per-cycle comparison, half a period after the edge
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                bit ed;
                ed = exp_rot[cyc] ? (exp_dir[cyc] ? reg_q[0] : reg_q[W-1]) : exp_din[cyc];
                check("sl",   int'(sl),   int'(exp_sl[cyc]));
                check("sr",   int'(sr),   int'(exp_sr[cyc]));
                check("busy", int'(busy), int'(exp_busy[cyc]));
                check("done", int'(done), int'(exp_done[cyc]));
                check("din",  int'(din),  int'(exp_busy[cyc] & ed));
                if (sl | sr) shifts_seen++;
                if (busy) busy_seen++;
                if (done) begin dones_seen++; last_done = cyc; end
            end
        end
    end

    task automatic cmd(input bit d, input logic [3:0] c, input logic [W-1:0] p, input bit r);
        @(negedge clk);
        start = 1'b1; dir = d; count = c; pattern = p; rotate = r;
        @(negedge clk);
        start = 1'b0; dir = $urandom_range(0, 1); count = 4'($urandom); pattern = W'($urandom);
    endtask

    task automatic preset(input logic [W-1:0] v);
        @(negedge clk);
        preset_en = 1'b1; preset_val = v;
        @(negedge clk);
        preset_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int s0, d0, b0, acc0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        idle(1);
        check("reset_state", int'({sl, sr, din, busy, done}), 0);

        // left, count 8, A5
        preset(8'h00);
        s0 = shifts_seen; d0 = dones_seen;
        cmd(1'b0, 4'd8, 8'hA5, 1'b0);
        acc0 = last_acc;
        check("a5_model_din", int'({exp_din[acc0], exp_din[acc0+1], exp_din[acc0+2], exp_din[acc0+3],
                                    exp_din[acc0+4], exp_din[acc0+5], exp_din[acc0+6], exp_din[acc0+7]}),
              int'(8'b1010_0101));
        idle(12);
        check("a5_shifts", shifts_seen - s0, 8);
        check("a5_q", int'(reg_q), int'(8'hA5));
        check("a5_done_lat", last_done - acc0, 8);
        check("a5_dones", dones_seen - d0, 1);

        // right, count 3, 06 into 00
        preset(8'h00);
        s0 = shifts_seen;
        cmd(1'b1, 4'd3, 8'h06, 1'b0);
        acc0 = last_acc;
        check("r3_model_din", int'({exp_din[acc0], exp_din[acc0+1], exp_din[acc0+2]}), int'(3'b011));
        idle(8);
        check("r3_shifts", shifts_seen - s0, 3);
        check("r3_q", int'(reg_q), int'(8'hC0));

        // count 0
        s0 = shifts_seen; d0 = dones_seen; b0 = busy_seen;
        cmd(1'b0, 4'd0, 8'hFF, 1'b0);
        acc0 = last_acc;
        idle(5);
        check("c0_shifts", shifts_seen - s0, 0);
        check("c0_busy", busy_seen - b0, 0);
        check("c0_dones", dones_seen - d0, 1);
        check("c0_done_lat", last_done - acc0, 0);

        // count 15 clamps to 8; second start mid-command ignored
        preset(8'h00);
        s0 = shifts_seen; d0 = dones_seen;
        cmd(1'b0, 4'd15, 8'h3C, 1'b0);
        idle(2);
        cmd(1'b1, 4'd2, 8'hFF, 1'b0);
        idle(12);
        check("c15_shifts", shifts_seen - s0, 8);
        check("c15_dones", dones_seen - d0, 1);
        check("c15_q", int'(reg_q), int'(8'h3C));

        // reset in shift cycle 3, then immediate new command
        d0 = dones_seen;
        cmd(1'b0, 4'd8, 8'hFF, 1'b0);
        idle(1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_outs", int'({sl, sr, din, busy, done}), 0);
        idle(3);
        check("rst_no_done", dones_seen - d0, 0);
        s0 = shifts_seen;
        @(negedge clk);
        start = 1'b1; dir = 1'b1; count = 4'd2; pattern = 8'h01;
        @(negedge clk);
        start = 1'b0;
        idle(6);
        check("rst_restart_shifts", shifts_seen - s0, 2);
        check("rst_restart_dones", dones_seen - d0, 1);

`ifdef SHIFT_SEQ_ROTATE_EN
        preset(8'h81);
        cmd(1'b0, 4'd1, 8'h00, 1'b1);
        idle(4);
        check("rot_q", int'(reg_q), int'(8'h03));
`endif

        // random traffic, checked cycle by cycle against the model
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            reset   = ($urandom_range(0, 49) == 0);
            start   = ($urandom_range(0, 2) == 0);
            dir     = $urandom_range(0, 1);
            count   = 4'($urandom);
            pattern = W'($urandom);
            rotate  = $urandom_range(0, 1);
        end
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        idle(20);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, which is the width of the controlled shift register and of pattern/q; the legal range is 2..15.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on posedge clk.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: command request, sampled only in IDLE.
REQ-005 The block SHALL have port dir, input, 1 bit: 0 = shift left (drive sl), 1 = shift right (drive sr); latched on accepted start.
REQ-006 The block SHALL have port count, input, 4 bits: number of shifts requested; latched on accepted start.
REQ-007 The block SHALL have port pattern, input, WIDTH bits: serial data source; latched on accepted start.
REQ-008 The block SHALL have port q, input, WIDTH bits: current contents of the controlled shift register (used only in rotate mode).
REQ-009 The block SHALL have port sl, output, 1 bit: shift-left command to the register.
REQ-010 The block SHALL have port sr, output, 1 bit: shift-right command to the register.
REQ-011 The block SHALL have port din, output, 1 bit: serial data to the register.
REQ-012 The block SHALL have port busy, output, 1 bit: high while a command is executing.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-015 IDLE with start=1 and count>0 SHALL latch dir/count/pattern (count>WIDTH clamped to WIDTH) and go to SHIFT next cycle.
REQ-016 IDLE with start=1 and count=0 SHALL go directly to DONE with no sl/sr asserted.
REQ-017 SHIFT SHALL last exactly N cycles (N = latched count); exactly one of sl/sr is high each of those cycles; then the FSM goes to DONE.
REQ-018 DONE SHALL last one cycle with done=1 and then return to IDLE; a start sampled during DONE is ignored.
REQ-019 Latency SHALL be as follows: start accepted at edge k -> sl/sr high in cycles k+1..k+N -> done high in cycle k+N+1 -> next start accepted at edge k+N+2 at the earliest.
REQ-020 busy SHALL equal (state==SHIFT); sl = busy & ~dir_r; sr = busy & dir_r; done = (state==DONE); all decoded from registers only.
REQ-021 In a left shift, din in shift i (i = 0..N-1) SHALL equal pattern_r[N-1-i], leaving q[N-1:0] = pattern[N-1:0].
REQ-022 In a right shift, din in shift i SHALL equal pattern_r[i], leaving q[WIDTH-1:WIDTH-N] = pattern[N-1:0].
REQ-023 din SHALL be 0 whenever busy=0.
REQ-024 start while busy SHALL be ignored; inputs SHALL NOT be relatched mid-command.
REQ-025 The internal shift counter SHALL be WIDTH-safe with no wrap: terminate when the remaining count reaches 1 in SHIFT.

Reset
REQ-026 reset=1 at a clock edge SHALL force IDLE with counter, dir_r and pattern_r cleared, giving sl=sr=din=busy=done=0 the following cycle.
REQ-027 reset SHALL take priority over start and over an in-progress command; an aborted command produces no done pulse.
REQ-028 The controlled register's contents SHALL NOT be restored by this block on reset.

Configuration
REQ-029 Macro SHIFT_SEQ_ROTATE_EN SHALL control rotate mode as follows.
REQ-030 When SHIFT_SEQ_ROTATE_EN is defined, the block SHALL have an extra input rotate (1 bit, latched on start); when latched rotate=1, din = q[WIDTH-1] for left and q[0] for right (combinational from q), and pattern is ignored.
REQ-031 When SHIFT_SEQ_ROTATE_EN is undefined, the block SHALL have no rotate port and din always comes from pattern_r.

Verification
REQ-032 The bench SHALL cover: start, dir=0, count=8, pattern=8'hA5 -> sl high 8 cycles, din=1,0,1,0,0,1,0,1; register ends 8'hA5; done in cycle 9.
REQ-033 The bench SHALL cover: start, dir=1, count=3, pattern=8'h06, register preset 8'h00 -> sr high 3 cycles, din=0,1,1; register ends 8'hC0.
REQ-034 The bench SHALL cover: start, count=0 -> no sl/sr; done one cycle later; busy never high.
REQ-035 The bench SHALL cover: start, count=15, WIDTH=8 -> exactly 8 shifts; second start pulse during cycle 4 ignored.
REQ-036 The bench SHALL cover: reset asserted in shift cycle 3 of a count=8 command -> next cycle all outputs 0; no done; new start accepted right after reset deasserts.
REQ-037 The bench SHALL cover, with SHIFT_SEQ_ROTATE_EN: rotate=1, dir=0, count=1, register 8'h81 -> din=1; register ends 8'h03.
